// File: rtl/btn_debouncer.sv
// Push-button conditioner: per channel a two-flop synchronizer, a counter-based
// debounce filter and a rising-edge one-shot. o_btn_level is the debounced level,
// o_btn_pulse is a single-cycle strobe on each debounced press.
module btn_debouncer #(
  parameter int unsigned NB_BTN          = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned NB_CNT          = 20
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic [NB_BTN-1:0] i_btn_raw,
  output logic [NB_BTN-1:0] o_btn_level,
  output logic [NB_BTN-1:0] o_btn_pulse
);

  // Terminal count: the filter flips on the DEBOUNCE_CYCLES-th differing sample.
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    STABLE_LOW  = 1'b0,
    STABLE_HIGH = 1'b1
  } state_e;

  logic [NB_BTN-1:0] sync1_q;
  logic [NB_BTN-1:0] sync2_q;

  // Two-flop synchronizer; the only logic that looks at the raw pins.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= i_btn_raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar g = 0; g < NB_BTN; g++) begin : g_chan
    state_e            state_q;
    logic [NB_CNT-1:0] cnt_q;
    logic              pulse_q;
    logic              s_c;

    assign s_c = sync2_q[g];

    // Debounce filter: count consecutive samples that disagree with the
    // debounced state, flip on the terminal count, strobe only on 0->1.
    always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
        state_q <= STABLE_LOW;
        cnt_q   <= '0;
        pulse_q <= 1'b0;
      end else begin
        pulse_q <= 1'b0;
        case (state_q)
          STABLE_LOW: begin
            if (!s_c) begin
              cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
              state_q <= STABLE_HIGH;
              cnt_q   <= '0;
              pulse_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + NB_CNT'(1);
            end
          end
          STABLE_HIGH: begin
            if (s_c) begin
              cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
              state_q <= STABLE_LOW;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + NB_CNT'(1);
            end
          end
          default: begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
          end
        endcase
      end
    end

    assign o_btn_level[g] = (state_q == STABLE_HIGH);
    assign o_btn_pulse[g] = pulse_q;
  end

endmodule

// File: tb/tb_btn_debouncer.sv
// Directed bench for btn_debouncer with a sliding-window reference model.
module tb_btn_debouncer;

  localparam int unsigned NB = 3;
  localparam int unsigned D  = 4;
  localparam int unsigned NC = 3;

  logic          clock;
  logic          i_reset;
  logic [NB-1:0] i_btn_raw;
  logic [NB-1:0] o_btn_level;
  logic [NB-1:0] o_btn_pulse;

  int n_checks = 0;
  int n_errors = 0;

  btn_debouncer #(
    .NB_BTN         (NB),
    .DEBOUNCE_CYCLES(D),
    .NB_CNT         (NC)
  ) dut (
    .clock      (clock),
    .i_reset    (i_reset),
    .i_btn_raw  (i_btn_raw),
    .o_btn_level(o_btn_level),
    .o_btn_pulse(o_btn_pulse)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the raw input reaches the filter two edges late; the
  // debounced level flips when the last D filter samples all disagree with it.
  logic [NB-1:0] m_p1, m_p2, m_level, m_pulse;
  logic [D-1:0]  m_win [NB];

  always @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      m_p1 = '0; m_p2 = '0; m_level = '0; m_pulse = '0;
      for (int c = 0; c < NB; c++) m_win[c] = '0;
    end else begin
      logic [NB-1:0] s_seen;
      s_seen = m_p2;
      m_p2   = m_p1;
      m_p1   = i_btn_raw;
      for (int c = 0; c < NB; c++) begin
        m_win[c]   = {m_win[c][D-2:0], s_seen[c]};
        m_pulse[c] = 1'b0;
        if (m_win[c] == {D{~m_level[c]}}) begin
          m_level[c] = ~m_level[c];
          m_pulse[c] = m_level[c];
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    chk("model_level", 32'(o_btn_level), 32'(m_level));
    chk("model_pulse", 32'(o_btn_pulse), 32'(m_pulse));
  end

  // Pulse bookkeeping for hand-computed expectations. Index 0 is the first
  // edge after the call, i.e. the edge that captures freshly driven inputs.
  int pcount [NB];
  int pfirst [NB];

  task automatic watch(input int n);
    for (int c = 0; c < NB; c++) begin
      pcount[c] = 0;
      pfirst[c] = -1;
    end
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      for (int c = 0; c < NB; c++) begin
        if (o_btn_pulse[c] === 1'b1) begin
          pcount[c]++;
          if (pfirst[c] < 0) pfirst[c] = i;
        end
      end
    end
  endtask

  task automatic set_raw(input logic [NB-1:0] v);
    #1;
    i_btn_raw = v;
  endtask

  initial begin
    clock     = 1'b0;
    i_reset   = 1'b1;
    i_btn_raw = 3'b111;

    // 1. Asynchronous reset with buttons held, then release.
    #1 i_reset = 1'b0;
    #1;
    chk("reset_level_noclk", 32'(o_btn_level), 32'd0);
    chk("reset_pulse_noclk", 32'(o_btn_pulse), 32'd0);
    repeat (3) @(posedge clock);
    #2 i_reset = 1'b1;
    watch(12);
    for (int c = 0; c < NB; c++) begin
      chk($sformatf("t1_first_ch%0d", c), 32'(pfirst[c]), 32'd5);
      chk($sformatf("t1_count_ch%0d", c), 32'(pcount[c]), 32'd1);
    end
    chk("t1_level", 32'(o_btn_level), 32'd7);

    set_raw(3'b000);
    watch(10);
    chk("release_level", 32'(o_btn_level), 32'd0);
    chk("release_nopulse", 32'(pcount[0] + pcount[1] + pcount[2]), 32'd0);

    // 2. Clean press on ch0 held for 20 cycles.
    set_raw(3'b001);
    watch(20);
    chk("t2_first", 32'(pfirst[0]), 32'd5);
    chk("t2_count", 32'(pcount[0]), 32'd1);
    chk("t2_level", 32'(o_btn_level), 32'd1);

    // 3. Bounce on ch1 while ch0 stays held.
    begin
      logic [6:0] pat;
      int         bounce_pulses;
      pat = 7'b1101110;
      bounce_pulses = 0;
      for (int i = 6; i >= 0; i--) begin
        set_raw({1'b0, pat[i], 1'b1});
        watch(1);
        bounce_pulses += pcount[1];
      end
      set_raw(3'b001);
      watch(10);
      bounce_pulses += pcount[1];
      chk("t3_nopulse", 32'(bounce_pulses), 32'd0);
      chk("t3_level", 32'(o_btn_level), 32'd1);
      chk("t3_ch0_no_repulse", 32'(pcount[0]), 32'd0);
    end

    // 4. Release ch0, then re-press it.
    set_raw(3'b000);
    watch(10);
    chk("t4_release_level", 32'(o_btn_level), 32'd0);
    chk("t4_release_nopulse", 32'(pcount[0]), 32'd0);
    set_raw(3'b001);
    watch(10);
    chk("t4_first", 32'(pfirst[0]), 32'd5);
    chk("t4_count", 32'(pcount[0]), 32'd1);

    set_raw(3'b000);
    watch(10);

    // 5. Simultaneous press on ch0 and ch2.
    set_raw(3'b101);
    watch(12);
    chk("t5_first_ch0", 32'(pfirst[0]), 32'd5);
    chk("t5_first_ch2", 32'(pfirst[2]), 32'd5);
    chk("t5_count_ch0", 32'(pcount[0]), 32'd1);
    chk("t5_count_ch2", 32'(pcount[2]), 32'd1);
    chk("t5_count_ch1", 32'(pcount[1]), 32'd0);
    chk("t5_level", 32'(o_btn_level), 32'd5);

    set_raw(3'b000);
    watch(10);

    // 6. Reset in the middle of a ch2 count, button still held on release.
    set_raw(3'b100);
    watch(4);
    #1 i_reset = 1'b0;
    #1;
    chk("t6_reset_level", 32'(o_btn_level), 32'd0);
    chk("t6_reset_pulse", 32'(o_btn_pulse), 32'd0);
    watch(3);
    chk("t6_nopulse_in_reset", 32'(pcount[2]), 32'd0);
    #1 i_reset = 1'b1;
    watch(10);
    chk("t6_first", 32'(pfirst[2]), 32'd5);
    chk("t6_count", 32'(pcount[2]), 32'd1);
    chk("t6_level", 32'(o_btn_level), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/btn_debouncer.md
Name: btn_debouncer

Overview:
Conditions the raw push-button inputs on the FPGA board before they reach the operand/operation capture registers of the ALU top level. Per channel: two-flop synchronizer, counter-based debounce filter, and rising-edge one-shot generator. o_btn_pulse drives the top level's i_btn directly, so one physical press loads A, B or the operation exactly once. o_btn_level exposes the debounced level.

Parameters:
NB_BTN, 3, number of independent button channels
DEBOUNCE_CYCLES, 1000000, consecutive clock cycles a synchronized input must differ from the debounced state before that state flips (10 ms at 100 MHz); legal range 2 .. 2^NB_CNT
NB_CNT, 20, width of each per-channel debounce counter

Ports:
clock  input  1  system clock; all state updates on rising edge
i_reset  input  1  asynchronous, active-low reset (0 = reset)
i_btn_raw  input  NB_BTN  raw, asynchronous, bouncing button inputs, active-high
o_btn_level  output  NB_BTN  debounced level per channel
o_btn_pulse  output  NB_BTN  one-clock pulse per channel on each debounced 0->1 transition

Behaviour:
- Reset (i_reset=0, asynchronous, no clock needed): sync stage 1 and stage 2, stable, cnt, o_btn_level and o_btn_pulse all 0. Deassertion is sampled on the next clock edge.
- Synchronizer: sync1 <= i_btn_raw; s <= sync1. No other logic reads i_btn_raw.
- Each channel has two states, STABLE_LOW and STABLE_HIGH (stable=0/1), plus the counter cnt.
- Each edge, per channel:
  - s == stable: cnt <= 0. Any matching sample aborts a count in progress (glitch rejection).
  - s != stable and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - s != stable and cnt == DEBOUNCE_CYCLES-1: stable <= s; cnt <= 0.
- Net effect: stable flips on the DEBOUNCE_CYCLES-th consecutive edge at which s differs from it.
- o_btn_level = stable (registered; no combinational path from inputs).
- o_btn_pulse is registered. It is 1 for exactly the one cycle in which stable is first seen 1 after a 0->1 flip, i.e. pulse <= (s & ~stable & cnt==DEBOUNCE_CYCLES-1). Otherwise 0.
- The 1->0 flip produces no pulse.
- Latency: raw edge captured by sync1 at edge E0 -> o_btn_level and o_btn_pulse change after edge E(DEBOUNCE_CYCLES+1).
- Holding a button never produces a second pulse. A new pulse requires a debounced release followed by a debounced press.
- Channels are fully independent. Simultaneous presses on several channels give simultaneous pulses in the same cycle.
- cnt never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Reset mid-count: all channel state clears. A button still held when reset deasserts is treated as a new press and yields one pulse after the full latency.
- Bounce shorter than DEBOUNCE_CYCLES cycles, in either direction, never changes o_btn_level and never pulses.

Test Plan:
(Bench uses DEBOUNCE_CYCLES=4, NB_BTN=3.)
1. Reset: hold i_reset=0 with i_btn_raw=3'b111, no clocks -> o_btn_level=0 and o_btn_pulse=0 immediately. Release reset -> ch0..2 each pulse once, 5 edges after the first post-reset sampling edge.
2. Clean press: raise i_btn_raw[0] and hold 20 cycles -> o_btn_level[0] rises and o_btn_pulse[0]=1 for exactly one cycle, 5 edges after the capturing edge. No further pulses while held.
3. Bounce: on i_btn_raw[1] drive 1,1,0,1,1,1,0 over 7 cycles, then 0 -> o_btn_level[1] stays 0 and o_btn_pulse[1] is never 1.
4. Release and re-press: after step 2, drop ch0 for 10 cycles, then raise it for 10 cycles -> level falls with no pulse, then exactly one new pulse.
5. Simultaneous: raise i_btn_raw=3'b101 on the same edge -> o_btn_pulse=3'b101 in a single cycle. Ch1 stays 0.
6. Reset mid-count: start a ch2 press, assert i_reset=0 after 2 counting cycles, release with the button still held -> no pulse during reset, one pulse after the full latency from release.
